// File: rtl/spu_op_any.sv
// OR-reduction of s_data with an optional clear/valid-qualified pipeline of 0..3 stages.
// Define SPU_OP_ANY_ASSERT_EN to compile the simulation-only self-checks.
module spu_op_any #(
    parameter int         LATENCY    = 1,
    parameter int         DATA_BITS  = 8,
    parameter type        data_t     = logic [DATA_BITS-1:0],
    parameter logic       CLEAR_DATA = 1'b0,
    parameter logic       USE_CLEAR  = 1'b0,
    parameter logic       USE_VALID  = 1'b0,
    parameter string      DEVICE     = "RTL",
    parameter string      SIMULATION = "false",
    parameter string      DEBUG      = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  data_t s_data,
    input  logic  s_clear,
    input  logic  s_valid,
    output logic  m_data
);

    if (LATENCY < 0 || LATENCY > 3) begin : g_bad_latency
        $error("spu_op_any: LATENCY must be in 0..3");
    end
    if (DATA_BITS < 1 || DATA_BITS > 64) begin : g_bad_width
        $error("spu_op_any: DATA_BITS must be in 1..64");
    end
    if ((SIMULATION != "true" && SIMULATION != "false") ||
        (DEBUG != "true" && DEBUG != "false")) begin : g_bad_flags
        $error("spu_op_any: SIMULATION and DEBUG must be \"true\" or \"false\"");
    end

    logic [DATA_BITS-1:0] w_flat;
    logic                 w_any;
    logic                 w_clear;
    logic                 w_load;

    assign w_flat  = s_data;
    assign w_clear = USE_CLEAR && s_clear;
    assign w_load  = s_valid || !USE_VALID;

    // Six-input groups line up with LUT6 boundaries; the result is the same plain OR.
    if (DEVICE == "ULTRASCALE_PLUS") begin : g_lut
        localparam int GROUPS = (DATA_BITS + 5) / 6;
        logic [GROUPS-1:0] w_grp;
        for (genvar g = 0; g < GROUPS; g++) begin : g_grp
            localparam int LO = g * 6;
            localparam int HI = (LO + 5 < DATA_BITS) ? LO + 5 : DATA_BITS - 1;
            assign w_grp[g] = |w_flat[HI:LO];
        end
        assign w_any = |w_grp;
    end else begin : g_rtl
        assign w_any = |w_flat;
    end

    if (LATENCY == 0) begin : g_comb
        assign m_data = w_clear ? CLEAR_DATA : w_any;
    end else begin : g_pipe
        logic [LATENCY-1:0] r_pipe;

        // NOTE: non-blocking assignments let every stage read its neighbour's old value.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_pipe <= '0;
            end else if (cke) begin
                if (w_clear) begin
                    r_pipe[0] <= CLEAR_DATA;
                end else if (w_load) begin
                    r_pipe[0] <= w_any;
                end
                for (int i = 1; i < LATENCY; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign m_data = r_pipe[LATENCY-1];
    end

`ifdef SPU_OP_ANY_ASSERT_EN
    // Behavioural model: history of loaded results, newest in bit 0.
    logic [3:0] r_chk_hist;
    logic       w_chk_exp;

    always @(posedge clk) begin
        if (reset) begin
            r_chk_hist <= '0;
        end else if (cke) begin
            r_chk_hist <= {r_chk_hist[2:0],
                           w_clear ? CLEAR_DATA : (w_load ? (|w_flat) : r_chk_hist[0])};
        end
    end

    assign w_chk_exp = (LATENCY == 0) ? (w_clear ? CLEAR_DATA : (|w_flat))
                                      : r_chk_hist[(LATENCY == 0) ? 0 : LATENCY-1];

    always @(negedge clk) begin
        if (!reset) begin
            assert (m_data === w_chk_exp)
            else $error("spu_op_any: m_data=%b model=%b", m_data, w_chk_exp);
        end
    end

    a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({s_clear, s_valid, cke}))
    else $error("spu_op_any: control input is X");
`endif

endmodule

// File: tb/tb_spu_op_any.sv
// Table-driven bench for spu_op_any: LATENCY=3 directed vectors, reset corner case,
// and a random sweep over several LATENCY/DATA_BITS builds against a history model.
module tb_spu_op_any;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        clr;
    logic        vld;
    logic [7:0]  d8;
    logic [63:0] drand;
    logic        m_main, m_l0, m_l1, m_l2;

    int total = 0;
    int bad   = 0;

    // Model histories: newest loaded result in bit 0.
    logic [3:0] h_main = '0, h_l1 = '0, h_l2 = '0;

    always #5 clk = ~clk;

    spu_op_any #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(1'b1),
                 .USE_CLEAR(1'b1), .USE_VALID(1'b1)) u_dut (
        .clk(clk), .reset(rst), .cke(cke), .s_data(d8),
        .s_clear(clr), .s_valid(vld), .m_data(m_main));

    spu_op_any #(.LATENCY(0), .DATA_BITS(1), .CLEAR_DATA(1'b0),
                 .USE_CLEAR(1'b1), .USE_VALID(1'b1)) u_l0 (
        .clk(clk), .reset(rst), .cke(cke), .s_data(drand[0:0]),
        .s_clear(clr), .s_valid(vld), .m_data(m_l0));

    spu_op_any #(.LATENCY(1), .DATA_BITS(64), .CLEAR_DATA(1'b0),
                 .USE_CLEAR(1'b0), .USE_VALID(1'b1), .DEVICE("ULTRASCALE_PLUS")) u_l1 (
        .clk(clk), .reset(rst), .cke(cke), .s_data(drand),
        .s_clear(clr), .s_valid(vld), .m_data(m_l1));

    spu_op_any #(.LATENCY(2), .DATA_BITS(13), .CLEAR_DATA(1'b1),
                 .USE_CLEAR(1'b1), .USE_VALID(1'b0)) u_l2 (
        .clk(clk), .reset(rst), .cke(cke), .s_data(drand[12:0]),
        .s_clear(clr), .s_valid(vld), .m_data(m_l2));

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit uc, input bit uv, input logic cl,
                              input logic red, inout logic [3:0] h);
        logic nv;
        if (rst) begin
            h = '0;
        end else if (cke) begin
            nv = (uc && clr) ? cl : ((vld || !uv) ? red : h[0]);
            h  = {h[2:0], nv};
        end
    endtask

    // One clock edge: update the models with the inputs that were sampled, then settle.
    task automatic step();
        @(posedge clk);
        model_edge(1'b1, 1'b1, 1'b1, |d8,          h_main);
        model_edge(1'b0, 1'b1, 1'b0, |drand,       h_l1);
        model_edge(1'b1, 1'b0, 1'b1, |drand[12:0], h_l2);
        #1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       clr;
        logic       vld;
        logic       ck;
        logic       exp;
    } vec_t;

    vec_t tbl[20];

    initial begin
        // d, clear, valid, cke, expected m_data after the edge
        tbl[0]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{8'h10, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; cke = 1'b0; clr = 1'b0; vld = 1'b1; d8 = 8'h00; drand = '0;
        step();
        step();
        check("reset_main", m_main, 1'b0);
        check("reset_l1",   m_l1,   1'b0);
        check("reset_l2",   m_l2,   1'b0);

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d8  = tbl[i].d;
            clr = tbl[i].clr;
            vld = tbl[i].vld;
            cke = tbl[i].ck;
            step();
            check($sformatf("vec%0d", i), m_main, tbl[i].exp);
        end

        // Fill the pipeline with 1s, then reset mid-stream with cke low and clear high.
        d8 = 8'hFF; clr = 1'b0; vld = 1'b1; cke = 1'b1;
        step(); step(); step();
        check("prefill", m_main, 1'b1);
        rst = 1'b1; cke = 1'b0; clr = 1'b1;
        step();
        check("rst_first_edge", m_main, 1'b0);
        cke = 1'b1;
        step();
        check("rst_second_edge", m_main, 1'b0);
        rst = 1'b0; clr = 1'b0; d8 = 8'hFF;
        step();
        check("post_rst_1", m_main, 1'b0);
        d8 = 8'h00;
        step();
        check("post_rst_2", m_main, 1'b0);
        step();
        check("post_rst_3", m_main, 1'b1);
        step();
        check("post_rst_4", m_main, 1'b0);

        // Random sweep with single-bit boundary patterns mixed in.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: drand = '0;
                1: drand = 64'd1 << $urandom_range(0, 63);
                2: drand = 64'h8000_0000_0000_0000;
                3: drand = 64'h0000_0000_0000_1000;
                4: drand = 64'd1;
                default: drand = {$urandom, $urandom};
            endcase
            d8  = ($urandom_range(0, 3) == 0) ? 8'h00 : drand[7:0];
            rst = ($urandom_range(0, 39) == 0);
            cke = ($urandom_range(0, 3) != 0);
            vld = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 19) < 3);
            step();
            check("rand_l3_d8",  m_main, h_main[2]);
            check("rand_l0_d1",  m_l0,   clr ? 1'b0 : drand[0]);
            check("rand_l1_d64", m_l1,   h_l1[0]);
            check("rand_l2_d13", m_l2,   h_l2[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
